// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared definitions for the UART receive controller slice.
// Holds the controller FSM encoding, default parameter values and the
// error-counter width / saturation value.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_PUSH = 2'd2
    } rx_state_t;

    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned TMO_CYC_DEF    = 32;
    localparam bit          DROP_BAD_DEF   = 1'b1;

    localparam int unsigned      ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_dat   write request and data (accepted when not full, or
//                    when full and popped in the same cycle)
//   pop, pop_dat     read request and head of queue (0 while empty)
//   cnt              occupancy, 0..DEPTH
//   empty, full      status
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic [AW:0]   cnt,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    // A full FIFO still accepts a write when a pop frees the slot this cycle;
    // a pop on an empty FIFO is ignored even if a write arrives.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: pulls bytes from a UART receiver into a receive FIFO.
// Ports:
//   clk24m, rst               clock, asynchronous active-high reset
//   rx_dat_rdy, rx_dat_i      receiver byte-ready flag and data
//   rx_frm_err, rx_pity_err   receiver error flags, sampled after the read
//   rx_rdn                    active-low read strobe to the receiver
//   fifo_rd, fifo_dat         host pop request, FIFO head (fall-through)
//   fifo_empty, fifo_full     FIFO status
//   fifo_cnt                  FIFO occupancy
//   err_cnt                   saturating count of bad bytes
//   ovf_err, tmo_err          sticky overflow / read-timeout flags
//   clr_err                   clears err_cnt, ovf_err and tmo_err
module uart_rx_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned TMO_CYC    = TMO_CYC_DEF,
    parameter bit          DROP_BAD   = DROP_BAD_DEF
) (
    input  logic                          clk24m,
    input  logic                          rst,
    input  logic                          rx_dat_rdy,
    input  logic [7:0]                    rx_dat_i,
    input  logic                          rx_frm_err,
    input  logic                          rx_pity_err,
    output logic                          rx_rdn,
    input  logic                          fifo_rd,
    output logic [7:0]                    fifo_dat,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic [ERR_W-1:0]              err_cnt,
    output logic                          ovf_err,
    output logic                          tmo_err,
    input  logic                          clr_err
);

    localparam int unsigned TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    dat_q;
    logic          tmo_hit;
    logic          bad;
    logic          push;
    logic          bad_evt;
    logic          ovf_evt;
    logic          tmo_evt;

    assign bad     = rx_frm_err | rx_pity_err;
    assign tmo_hit = (state == ST_READ) && (tmo_cnt == TW'(TMO_CYC - 1));

    // State register
    always_ff @(posedge clk24m or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (rx_dat_rdy)            state_nxt = ST_READ;
            ST_READ: if (!rx_dat_rdy || tmo_hit) state_nxt = ST_PUSH;
            ST_PUSH:                            state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    // Outputs; rx_rdn decodes straight from the state so reset releases it
    // without waiting for a clock.
    always_comb begin
        rx_rdn = 1'b1;
        push   = 1'b0;
        case (state)
            ST_READ: rx_rdn = 1'b0;
            ST_PUSH: push   = !(bad && DROP_BAD);
            default: ;
        endcase
    end

    // Timeout counter and data latch
    always_ff @(posedge clk24m or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            dat_q   <= '0;
        end else if (state == ST_READ) begin
            tmo_cnt <= tmo_cnt + TW'(1);
            dat_q   <= rx_dat_i;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign bad_evt = (state == ST_PUSH) && bad;
    assign ovf_evt = push && fifo_full && !fifo_rd;
    // A normal release on the last allowed cycle is not a timeout.
    assign tmo_evt = tmo_hit && rx_dat_rdy;

    always_ff @(posedge clk24m or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            ovf_err <= 1'b0;
            tmo_err <= 1'b0;
        end else if (clr_err) begin
            err_cnt <= '0;
            ovf_err <= 1'b0;
            tmo_err <= 1'b0;
        end else begin
            if (bad_evt && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (ovf_evt) begin
                ovf_err <= 1'b1;
            end
            if (tmo_evt) begin
                tmo_err <= 1'b1;
            end
        end
    end

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk      (clk24m),
        .rst      (rst),
        .push     (push),
        .push_dat (dat_q),
        .pop      (fifo_rd),
        .pop_dat  (fifo_dat),
        .cnt      (fifo_cnt),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic       clk24m = 1'b0;
    logic       rst = 1'b1;
    logic       rx_dat_rdy = 1'b0;
    logic [7:0] rx_dat_i = 8'h00;
    logic       rx_frm_err = 1'b0;
    logic       rx_pity_err = 1'b0;
    logic       fifo_rd = 1'b0;
    logic       clr_err = 1'b0;

    logic       rx_rdn, fifo_empty, fifo_full, ovf_err, tmo_err;
    logic [7:0] fifo_dat, err_cnt;
    logic [3:0] fifo_cnt;

    logic       k_rx_rdn, k_fifo_empty, k_fifo_full, k_ovf_err, k_tmo_err;
    logic [7:0] k_fifo_dat, k_err_cnt;
    logic [3:0] k_fifo_cnt;

    int n_chk = 0;
    int n_err = 0;
    int lowc;

    always #5 clk24m = ~clk24m;

    uart_rx_ctrl #(
        .FIFO_DEPTH (8),
        .TMO_CYC    (32),
        .DROP_BAD   (1'b1)
    ) dut (
        .clk24m      (clk24m),
        .rst         (rst),
        .rx_dat_rdy  (rx_dat_rdy),
        .rx_dat_i    (rx_dat_i),
        .rx_frm_err  (rx_frm_err),
        .rx_pity_err (rx_pity_err),
        .rx_rdn      (rx_rdn),
        .fifo_rd     (fifo_rd),
        .fifo_dat    (fifo_dat),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_cnt    (fifo_cnt),
        .err_cnt     (err_cnt),
        .ovf_err     (ovf_err),
        .tmo_err     (tmo_err),
        .clr_err     (clr_err)
    );

    uart_rx_ctrl #(
        .FIFO_DEPTH (8),
        .TMO_CYC    (32),
        .DROP_BAD   (1'b0)
    ) dut_keep (
        .clk24m      (clk24m),
        .rst         (rst),
        .rx_dat_rdy  (rx_dat_rdy),
        .rx_dat_i    (rx_dat_i),
        .rx_frm_err  (rx_frm_err),
        .rx_pity_err (rx_pity_err),
        .rx_rdn      (k_rx_rdn),
        .fifo_rd     (fifo_rd),
        .fifo_dat    (k_fifo_dat),
        .fifo_empty  (k_fifo_empty),
        .fifo_full   (k_fifo_full),
        .fifo_cnt    (k_fifo_cnt),
        .err_cnt     (k_err_cnt),
        .ovf_err     (k_ovf_err),
        .tmo_err     (k_tmo_err),
        .clr_err     (clr_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_dat_rdy = 1'b0;
        rx_frm_err = 1'b0;
        rx_pity_err = 1'b0;
        fifo_rd = 1'b0;
        clr_err = 1'b0;
        @(posedge clk24m); #1;
        rst = 1'b0;
        @(posedge clk24m); #1;
    endtask

    // Receiver model: raises rx_dat_rdy, drops it once rx_rdn has been seen
    // low for 'hold' cycles (hold=0: never drops), returns the low count.
    // fifo_rd is driven during the push cycle when pop_push is set.
    task automatic send(input logic [7:0] b, input logic fe, input logic pe,
                        input int hold, input logic pop_push, output int lc);
        bit seen_low = 0;
        bit done = 0;
        lc = 0;
        rx_dat_i = b;
        rx_frm_err = fe;
        rx_pity_err = pe;
        rx_dat_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk24m); #1;
            if (!rx_rdn) begin
                lc++;
                seen_low = 1;
                if (hold != 0 && lc == hold) rx_dat_rdy = 1'b0;
            end else if (seen_low) begin
                fifo_rd = pop_push;
                done = 1;
                break;
            end
        end
        if (!done) check_eq("rdn_release_bound", 32'(done), 32'd1);
        rx_dat_rdy = 1'b0;
        @(posedge clk24m); #1;
        fifo_rd = 1'b0;
        rx_frm_err = 1'b0;
        rx_pity_err = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_eq(tag, 32'(fifo_dat), 32'(exp));
        fifo_rd = 1'b1;
        @(posedge clk24m); #1;
        fifo_rd = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk24m); #1;
        check_eq("rst_rdn", 32'(rx_rdn), 32'd1);
        check_eq("rst_empty", 32'(fifo_empty), 32'd1);
        check_eq("rst_full", 32'(fifo_full), 32'd0);
        check_eq("rst_cnt", 32'(fifo_cnt), 32'd0);
        check_eq("rst_dat", 32'(fifo_dat), 32'd0);
        check_eq("rst_errcnt", 32'(err_cnt), 32'd0);
        check_eq("rst_ovf", 32'(ovf_err), 32'd0);
        check_eq("rst_tmo", 32'(tmo_err), 32'd0);
        rst = 1'b0;
        @(posedge clk24m); #1;

        // Single clean byte, read strobe 5 cycles
        send(8'hA5, 1'b0, 1'b0, 5, 1'b0, lowc);
        check_eq("a5_lowc", 32'(lowc), 32'd5);
        check_eq("a5_dat", 32'(fifo_dat), 32'hA5);
        check_eq("a5_cnt", 32'(fifo_cnt), 32'd1);
        check_eq("a5_empty", 32'(fifo_empty), 32'd0);

        // Push with pop while empty: pop ignored
        do_reset();
        send(8'h5A, 1'b0, 1'b0, 1, 1'b1, lowc);
        check_eq("pe_lowc", 32'(lowc), 32'd1);
        check_eq("pe_cnt", 32'(fifo_cnt), 32'd1);
        check_eq("pe_dat", 32'(fifo_dat), 32'h5A);

        // Nine bytes into depth 8: overflow, ordering kept
        do_reset();
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b0, 2, 1'b0, lowc);
        check_eq("ovf_full", 32'(fifo_full), 32'd1);
        check_eq("ovf_flag", 32'(ovf_err), 32'd1);
        check_eq("ovf_cnt", 32'(fifo_cnt), 32'd8);
        check_eq("ovf_errcnt", 32'(err_cnt), 32'd0);
        for (int i = 1; i <= 8; i++) pop_check("ovf_pop", 8'(i));
        check_eq("drain_empty", 32'(fifo_empty), 32'd1);
        fifo_rd = 1'b1;
        @(posedge clk24m); #1;
        fifo_rd = 1'b0;
        check_eq("underflow_cnt", 32'(fifo_cnt), 32'd0);
        check_eq("underflow_empty", 32'(fifo_empty), 32'd1);

        // Parity error: dropped vs stored
        do_reset();
        send(8'h3C, 1'b0, 1'b1, 3, 1'b0, lowc);
        check_eq("par_drop_empty", 32'(fifo_empty), 32'd1);
        check_eq("par_drop_errcnt", 32'(err_cnt), 32'd1);
        check_eq("par_keep_dat", 32'(k_fifo_dat), 32'h3C);
        check_eq("par_keep_cnt", 32'(k_fifo_cnt), 32'd1);
        check_eq("par_keep_errcnt", 32'(k_err_cnt), 32'd1);
        send(8'h55, 1'b1, 1'b0, 2, 1'b0, lowc);
        check_eq("frm_errcnt", 32'(err_cnt), 32'd2);
        check_eq("frm_drop_cnt", 32'(fifo_cnt), 32'd0);
        // Clear held across a bad-byte push: clear wins
        clr_err = 1'b1;
        send(8'h66, 1'b1, 1'b1, 2, 1'b0, lowc);
        clr_err = 1'b0;
        check_eq("clr_win_errcnt", 32'(err_cnt), 32'd0);

        // err_cnt saturation
        for (int i = 0; i < 257; i++) send(8'hEE, 1'b1, 1'b0, 1, 1'b0, lowc);
        check_eq("sat_errcnt", 32'(err_cnt), 32'd255);
        check_eq("sat_empty", 32'(fifo_empty), 32'd1);

        // Read timeout
        do_reset();
        send(8'h77, 1'b0, 1'b0, 0, 1'b0, lowc);
        check_eq("tmo_lowc", 32'(lowc), 32'd32);
        check_eq("tmo_flag", 32'(tmo_err), 32'd1);
        check_eq("tmo_cnt", 32'(fifo_cnt), 32'd1);
        clr_err = 1'b1;
        @(posedge clk24m); #1;
        clr_err = 1'b0;
        check_eq("tmo_clr", 32'(tmo_err), 32'd0);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, 1'b0, 2, 1'b0, lowc);
        check_eq("fpp_full_before", 32'(fifo_full), 32'd1);
        check_eq("fpp_head_before", 32'(fifo_dat), 32'h10);
        send(8'h18, 1'b0, 1'b0, 2, 1'b1, lowc);
        check_eq("fpp_cnt", 32'(fifo_cnt), 32'd8);
        check_eq("fpp_ovf", 32'(ovf_err), 32'd0);
        for (int i = 1; i <= 8; i++) pop_check("fpp_pop", 8'h10 + 8'(i));
        check_eq("fpp_empty", 32'(fifo_empty), 32'd1);

        // Reset mid-READ with bytes queued
        do_reset();
        for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 1'b0, 1'b0, 2, 1'b0, lowc);
        check_eq("mid_cnt_before", 32'(fifo_cnt), 32'd3);
        rx_dat_i = 8'hDD;
        rx_dat_rdy = 1'b1;
        @(posedge clk24m); #1;
        check_eq("mid_in_read", 32'(rx_rdn), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_rdn", 32'(rx_rdn), 32'd1);
        check_eq("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
        check_eq("mid_rst_empty", 32'(fifo_empty), 32'd1);
        rx_dat_rdy = 1'b0;
        @(posedge clk24m); #1;
        rst = 1'b0;
        @(posedge clk24m); #1;
        check_eq("mid_after_cnt", 32'(fifo_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameters: FIFO_DEPTH, default 8, receive FIFO entries (power of 2, 2..16).
REQ-002 Parameters: TMO_CYC, default 32, clk24m cycles allowed for rx_dat_rdy to clear after the read strobe starts.
REQ-003 Parameters: DROP_BAD, default 1; 1 discards bytes that carry frame or parity errors, 0 stores them.
REQ-004 Ports: clk24m, in, 1, system clock; rst, in, 1, reset, asynchronous, active-high.
REQ-005 Ports: rx_dat_rdy, in, 1, receiver byte-ready flag.
REQ-006 Ports: rx_dat_i, in, 8, receiver data bus, valid while rx_rdn is low.
REQ-007 Ports: rx_frm_err and rx_pity_err, in, 1 each, receiver error flags.
REQ-008 Ports: rx_rdn, out, 1, active-low read strobe to the receiver.
REQ-009 Ports: fifo_rd, in, 1, host pop request.
REQ-010 Ports: fifo_dat, out, 8, FIFO head, first-word fall-through.
REQ-011 Ports: fifo_empty and fifo_full, out, 1 each, FIFO status.
REQ-012 Ports: fifo_cnt, out, log2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-013 Ports: err_cnt, out, 8, saturating count of bad bytes.
REQ-014 Ports: ovf_err and tmo_err, out, 1 each, sticky overflow and timeout flags.
REQ-015 Ports: clr_err, in, 1, clears err_cnt, ovf_err and tmo_err.

Function
REQ-016 FSM states and transitions:
- IDLE: rx_rdn=1; goes to READ when rx_dat_rdy=1.
- READ: rx_rdn=0; latches rx_dat_i every cycle; timeout counter counts up from 0. Goes to PUSH when rx_dat_rdy=0, or when the counter reaches TMO_CYC-1, which also sets tmo_err.
- PUSH: rx_rdn=1; samples rx_frm_err and rx_pity_err; performs the write decision; goes to IDLE.
REQ-017 Latency: a byte appears at fifo_dat no later than 2 cycles after PUSH, given the FIFO was empty.
REQ-018 Bad byte (either error flag high in PUSH): err_cnt increments and saturates at 255. With DROP_BAD=1 the byte is not written.
REQ-019 Write into a full FIFO with no pop in the same cycle: byte dropped, ovf_err set, err_cnt unchanged.
REQ-020 Push and pop in the same cycle while full: both succeed; fifo_cnt is unchanged.
REQ-021 Push and pop in the same cycle while empty: the byte is written and fifo_cnt becomes 1; the pop is ignored.
REQ-022 Pop while empty is ignored; fifo_cnt never underflows.
REQ-023 FIFO pointers wrap modulo FIFO_DEPTH; ordering is strict FIFO.
REQ-024 clr_err in the same cycle as an increment or set event: the clear wins, and all three error outputs become 0.
REQ-025 rx_rdn is never low for more than TMO_CYC consecutive cycles.

Reset
REQ-026 rst asserted asynchronously forces: FSM to IDLE, rx_rdn=1, FIFO empty (fifo_empty=1, fifo_full=0, fifo_cnt=0), fifo_dat=0, err_cnt=0, ovf_err=0, tmo_err=0.
REQ-027 rst asserted mid-READ releases rx_rdn immediately; the partial byte is lost.
REQ-028 Release of rst is taken synchronously to clk24m; the first transition out of IDLE is possible one cycle after release.

Structure
REQ-029 Shared package uart_ctrl_pkg holds the FSM state encoding, default parameter values, and the err_cnt width and saturation constant.
REQ-030 The FIFO storage and pointers sit in one sub-module, uart_sync_fifo, with ports for push, pop, data and count.
REQ-031 uart_rx_ctrl holds the FSM, timeout counter and error logic only.

Verification
REQ-032 Byte 0xA5, flags 0; rx_dat_rdy drops 5 cycles into READ -> rx_rdn low for exactly 5 cycles, fifo_dat=0xA5, fifo_cnt=1.
REQ-033 Nine clean bytes 0x01..0x09, no pops, FIFO_DEPTH=8 -> fifo_full=1, ovf_err=1; popping returns 0x01..0x08.
REQ-034 Byte 0x3C with rx_pity_err=1, DROP_BAD=1 -> fifo_empty stays 1, err_cnt=1. Same case with DROP_BAD=0 -> 0x3C stored, err_cnt=1.
REQ-035 rx_dat_rdy held high -> rx_rdn returns high after 32 cycles, tmo_err=1; clr_err then clears tmo_err to 0.
REQ-036 Full FIFO with a push and fifo_rd in the same cycle -> fifo_cnt stays 8, ovf_err stays 0, new byte is last out.
REQ-037 rst pulsed during READ with 3 bytes queued -> rx_rdn=1 and fifo_cnt=0 immediately, before the next clock edge.
